muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer owning the HI/LO registers for the pipelined MIPS core. It accepts one operation per `start` pulse from the E stage, holds `busy` for a fixed per-class latency, then commits the result to HI/LO. The hazard stall detector consumes `busy` and `start` to hold mfhi/mflo/mult/div in D. Exception flush from the pipeline aborts an in-flight operation without touching HI/LO.

---
 rtl/muldiv_pkg.sv | 48 ++++
 rtl/muldiv_core.sv | 65 ++++++
 rtl/muldiv_sequencer.sv | 122 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Op encodings, FSM states and default latencies for the
//               multiply/divide sequencer. MULDIV_MADD_EN enables the
//               MADD/MADDU/MSUB/MSUBU accumulate ops.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [3:0] c_OP_MULT  = 4'd0;
    localparam logic [3:0] c_OP_MULTU = 4'd1;
    localparam logic [3:0] c_OP_DIV   = 4'd2;
    localparam logic [3:0] c_OP_DIVU  = 4'd3;
    localparam logic [3:0] c_OP_MTHI  = 4'd4;
    localparam logic [3:0] c_OP_MTLO  = 4'd5;
    localparam logic [3:0] c_OP_MADD  = 4'd6;
    localparam logic [3:0] c_OP_MADDU = 4'd7;
    localparam logic [3:0] c_OP_MSUB  = 4'd8;
    localparam logic [3:0] c_OP_MSUBU = 4'd9;

    localparam int c_DEF_MULT_LAT = 5;
    localparam int c_DEF_DIV_LAT  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // Accumulate ops only join the multiply class when the feature is built
    // in; otherwise they are never accepted and behave as no-ops.
    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MULDIV_MADD_EN
        return (op == c_OP_MULT) || (op == c_OP_MULTU) ||
               (op == c_OP_MADD) || (op == c_OP_MADDU) ||
               (op == c_OP_MSUB) || (op == c_OP_MSUBU);
`else
        return (op == c_OP_MULT) || (op == c_OP_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == c_OP_DIV) || (op == c_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_core
// Description : Combinational 64-bit HI/LO result from latched op/operands
//               and current HI/LO (accumulate ops reachable only with
//               MULDIV_MADD_EN, gated by the sequencer's op classifier).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_result,
    output logic        o_we
);

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [63:0]        w_acc;
    logic               w_signed_div;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_b_den;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
    assign w_acc    = {i_hi, i_lo};

    // Signed divide runs on magnitudes, so 0x80000000 / -1 lands on
    // LO=0x80000000, HI=0 without any overflow special case.
    assign w_signed_div = (i_op == c_OP_DIV);
    assign w_a_mag = (w_signed_div && i_a[31]) ? (~i_a + 32'd1) : i_a;
    assign w_b_mag = (w_signed_div && i_b[31]) ? (~i_b + 32'd1) : i_b;
    assign w_b_den = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag = w_a_mag / w_b_den;
    assign w_r_mag = w_a_mag % w_b_den;
    assign w_quot  = (w_signed_div && (i_a[31] ^ i_b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem   = (w_signed_div && i_a[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        o_result = w_acc;
        o_we     = 1'b0;
        case (i_op)
            c_OP_MULT:  begin o_result = $unsigned(w_prod_s);         o_we = 1'b1; end
            c_OP_MULTU: begin o_result = w_prod_u;                    o_we = 1'b1; end
            c_OP_DIV,
            c_OP_DIVU:  begin o_result = {w_rem, w_quot};             o_we = (i_b != 32'd0); end
            c_OP_MADD:  begin o_result = w_acc + $unsigned(w_prod_s); o_we = 1'b1; end
            c_OP_MADDU: begin o_result = w_acc + w_prod_u;            o_we = 1'b1; end
            c_OP_MSUB:  begin o_result = w_acc - $unsigned(w_prod_s); o_we = 1'b1; end
            c_OP_MSUBU: begin o_result = w_acc - w_prod_u;            o_we = 1'b1; end
            default:    begin o_result = w_acc;                       o_we = 1'b0; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle multiply/divide sequencer owning HI/LO, with
//               fixed per-class latency and flush abort. Optional
//               MULDIV_MADD_EN enables accumulate ops.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MULT_LAT = c_DEF_MULT_LAT,
    parameter int DIV_LAT  = c_DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_MULT_LAT = 4'(MULT_LAT);
    localparam logic [3:0] c_DIV_LAT  = 4'(DIV_LAT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_busy;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_accept_mul;
    logic        w_accept_div;
    logic        w_commit;
    logic [63:0] w_result;
    logic        w_result_we;

    assign w_accept     = start && !flush && (r_state == ST_IDLE);
    assign w_accept_mul = w_accept && is_mul_op(op);
    assign w_accept_div = w_accept && is_div_op(op);
    assign w_commit     = (r_state != ST_IDLE) && !flush && (r_cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_mul)      w_state_nxt = ST_MUL;
                else if (w_accept_div) w_state_nxt = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (flush || (r_cnt == 4'd1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
            r_op  <= 4'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
        end else if (w_accept_mul || w_accept_div) begin
            r_cnt <= w_accept_mul ? c_MULT_LAT : c_DIV_LAT;
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
        end else if (r_state != ST_IDLE) begin
            r_cnt <= (flush || (r_cnt == 4'd1)) ? 4'd0 : (r_cnt - 4'd1);
        end
    end

    muldiv_core u_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_result (w_result),
        .o_we     (w_result_we)
    );

    // MTHI/MTLO only reach here when idle; a commit and a move can never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit && w_result_we) begin
            r_hi <= w_result[63:32];
            r_lo <= w_result[31:0];
        end else if (w_accept && (op == c_OP_MTHI)) begin
            r_hi <= a;
        end else if (w_accept && (op == c_OP_MTLO)) begin
            r_lo <= a;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer: directed steps plus
//               random ops against an arithmetic HI/LO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: HI/LO behaviour straight from the arithmetic rules.
    task automatic model(input logic [3:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p, acc;
        sa  = longint'($signed(ia));
        sb  = longint'($signed(ib));
        acc = {m_hi, m_lo};
        lat = 0;
        case (o)
            4'd0: begin p = sa * sb; {m_hi, m_lo} = p; lat = MULT_LAT; end
            4'd1: begin p = {32'd0, ia} * {32'd0, ib}; {m_hi, m_lo} = p; lat = MULT_LAT; end
            4'd2: begin
                lat = DIV_LAT;
                if (ib != 0) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            4'd3: begin
                lat = DIV_LAT;
                if (ib != 0) begin m_lo = ia / ib; m_hi = ia % ib; end
            end
            4'd4: m_hi = ia;
            4'd5: m_lo = ia;
`ifdef MULDIV_MADD_EN
            4'd6: begin p = sa * sb; {m_hi, m_lo} = acc + p; lat = MULT_LAT; end
            4'd7: begin p = {32'd0, ia} * {32'd0, ib}; {m_hi, m_lo} = acc + p; lat = MULT_LAT; end
            4'd8: begin p = sa * sb; {m_hi, m_lo} = acc - p; lat = MULT_LAT; end
            4'd9: begin p = {32'd0, ia} * {32'd0, ib}; {m_hi, m_lo} = acc - p; lat = MULT_LAT; end
`endif
            default: lat = 0;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [31:0] ia, input logic [31:0] ib);
        int lat;
        int n;
        @(negedge clk);
        chk({tag, "_idle_before_start"}, {63'd0, busy}, 64'd0);
        start = 1'b1; op = o; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0;
        model(o, ia, ib, lat);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(lat));
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult_neg2x3", 4'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg2x3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        run_op("divu_100_7", 4'd3, 32'd100, 32'd7);
        chk("divu_100_7_const", {hi, lo}, {32'd2, 32'd14});
        run_op("multu_b2b", 4'd1, 32'hFFFF_FFFF, 32'd2);
        chk("multu_b2b_const", {hi, lo}, {32'd1, 32'hFFFF_FFFE});

        run_op("div_neg7_2", 4'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg7_2_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_by_zero", 4'd2, 32'd1234, 32'd0);
        chk("div_by_zero_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 4'd4; a = 32'h1234_5678; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("mthi_flushed_busy", {63'd0, busy}, 64'd0);
        chk("mthi_flushed_hilo", {hi, lo}, {m_hi, m_lo});
        run_op("mtlo_abcd", 4'd5, 32'h0000_ABCD, 32'd0);
        chk("mtlo_abcd_const", {32'd0, lo}, 64'h0000_ABCD);

        run_op("div_overflow", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_overflow_const", {hi, lo}, {32'd0, 32'h8000_0000});

        @(negedge clk);
        start = 1'b1; op = 4'd2; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_div_busy_before", {63'd0, busy}, 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_div_busy_after", {63'd0, busy}, 64'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("flush_div_still_idle", {63'd0, busy}, 64'd0);
        chk("flush_div_hilo", {hi, lo}, {m_hi, m_lo});

        run_op("madd_prep_hi", 4'd4, 32'd0, 32'd0);
        run_op("madd_prep_lo", 4'd5, 32'hFFFF_FFFF, 32'd0);
        run_op("maddu_1x1", 4'd7, 32'd1, 32'd1);
`ifdef MULDIV_MADD_EN
        chk("maddu_1x1_const", {hi, lo}, {32'd1, 32'd0});
`else
        chk("maddu_1x1_const", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

        for (int i = 0; i < 30; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            ro = 4'($urandom_range(0, 11));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end

        run_op("pre_reset_mthi", 4'd4, 32'hDEAD_BEEF, 32'd0);
        @(negedge clk);
        start = 1'b1; op = 4'd0; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_mid_mult_busy", {63'd0, busy}, 64'd0);
        chk("reset_mid_mult_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (6) @(posedge clk);
        #1;
        chk("reset_mid_mult_no_commit", {hi, lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
